// File: rtl/upsample_pkg.sv
// Shared types and constants for the 6-tap chroma upsampling controller.
package upsample_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ACC0,
      ST_ACC1,
      ST_ACC2,
      ST_ACC3,
      ST_ACC4,
      ST_ACC5,
      ST_DONE
   } state_e;

   localparam int          N_TAPS     = 6;
   localparam int          COEF_OUTER = 21;
   localparam int          COEF_MID   = 52;
   localparam int          COEF_INNER = 159;
   // Taps 1 and 4 carry the negative coefficients.
   localparam logic [5:0]  SUB_MASK   = 6'b010010;
   localparam int          ROUND_BIAS = 128;
   localparam int          OUT_SHIFT  = 8;

endpackage

// File: rtl/milestone1_mac.sv
// Shared accumulate/subtract MAC: loads a default, or adds/subtracts a value each enabled cycle.
module milestone1_mac #(
   parameter int ACC_W = 32
) (
   input  logic             Clock_50,
   input  logic             Resetn,
   input  logic             enable_ffn,
   input  logic             use_default,
   input  logic             subtract,
   input  logic [ACC_W-1:0] reset_parameter,
   input  logic [ACC_W-1:0] value,
   output logic [ACC_W-1:0] result
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (use_default)
         acc_d = reset_parameter;
      else if (subtract)
         acc_d = acc_q - value;
      else
         acc_d = acc_q + value;
   end

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn)
         acc_q <= '0;
      else if (!enable_ffn)
         acc_q <= acc_d;
   end

   assign result = acc_q;

endmodule

// File: rtl/upsample_fir_ctrl.sv
// Sequences one 6-tap interpolation on the shared MAC and presents the clipped 8-bit result.
//
// state | meaning
// IDLE  | in_ready high, waiting for a tap group
// LOAD  | MAC loads the rounding bias
// ACCk  | MAC adds/subtracts |coef[k]| * sample[k]
// DONE  | out_valid high, waiting for out_ready
module upsample_fir_ctrl
   import upsample_pkg::*;
#(
   parameter int SAMPLE_W = 8,
   parameter int ACC_W    = 32
) (
   input  logic                       Clock_50,
   input  logic                       Resetn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_TAPS*SAMPLE_W-1:0] in_samples,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SAMPLE_W-1:0]        out_data,
   output logic [ACC_W-1:0]           out_raw
);

   localparam logic [ACC_W-1:0] C_OUTER = ACC_W'(COEF_OUTER);
   localparam logic [ACC_W-1:0] C_MID   = ACC_W'(COEF_MID);
   localparam logic [ACC_W-1:0] C_INNER = ACC_W'(COEF_INNER);
   localparam logic [ACC_W-1:0] C_BIAS  = ACC_W'(ROUND_BIAS);

   state_e                      state_q, state_d;
   logic [N_TAPS*SAMPLE_W-1:0]  samples_q;
   logic [2:0]                  tap_idx;
   logic [SAMPLE_W-1:0]         tap_smp;
   logic [ACC_W-1:0]            tap_ext;
   logic [ACC_W-1:0]            mac_value;
   logic                        mac_en_n, mac_default, mac_sub;
   logic [ACC_W-1:0]            acc;
   logic                        accepting;

   assign accepting = in_valid && in_ready;

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accepting) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_ACC0;
         ST_ACC0: state_d = ST_ACC1;
         ST_ACC1: state_d = ST_ACC2;
         ST_ACC2: state_d = ST_ACC3;
         ST_ACC3: state_d = ST_ACC4;
         ST_ACC4: state_d = ST_ACC5;
         ST_ACC5: state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      mac_en_n    = 1'b1;
      mac_default = 1'b0;
      mac_sub     = 1'b0;
      tap_idx     = 3'd0;
      case (state_q)
         ST_IDLE: in_ready  = 1'b1;
         ST_DONE: out_valid = 1'b1;
         ST_LOAD: begin
            mac_en_n    = 1'b0;
            mac_default = 1'b1;
         end
         ST_ACC0: begin mac_en_n = 1'b0; tap_idx = 3'd0; end
         ST_ACC1: begin mac_en_n = 1'b0; tap_idx = 3'd1; end
         ST_ACC2: begin mac_en_n = 1'b0; tap_idx = 3'd2; end
         ST_ACC3: begin mac_en_n = 1'b0; tap_idx = 3'd3; end
         ST_ACC4: begin mac_en_n = 1'b0; tap_idx = 3'd4; end
         ST_ACC5: begin mac_en_n = 1'b0; tap_idx = 3'd5; end
         default: ;
      endcase
      if (!mac_en_n && !mac_default)
         mac_sub = SUB_MASK[tap_idx];
   end

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn)
         samples_q <= '0;
      else if (accepting)
         samples_q <= in_samples;
   end

   // Constant multiply per tap select; the sign is applied by the MAC subtract input.
   always_comb begin
      tap_smp = samples_q[int'(tap_idx)*SAMPLE_W +: SAMPLE_W];
      tap_ext = {{(ACC_W-SAMPLE_W){1'b0}}, tap_smp};
      case (tap_idx)
         3'd0, 3'd5: mac_value = tap_ext * C_OUTER;
         3'd1, 3'd4: mac_value = tap_ext * C_MID;
         default:    mac_value = tap_ext * C_INNER;
      endcase
   end

   milestone1_mac #(.ACC_W(ACC_W)) u_mac (
      .Clock_50        (Clock_50),
      .Resetn          (Resetn),
      .enable_ffn      (mac_en_n),
      .use_default     (mac_default),
      .subtract        (mac_sub),
      .reset_parameter (C_BIAS),
      .value           (mac_value),
      .result          (acc)
   );

   always_comb begin
      if (acc[ACC_W-1])
         out_data = '0;
      else if (|acc[ACC_W-2:SAMPLE_W+OUT_SHIFT])
         out_data = '1;
      else
         out_data = acc[SAMPLE_W+OUT_SHIFT-1:OUT_SHIFT];
   end

   assign out_raw = acc;

endmodule

// File: tb/tb_upsample_fir_ctrl.sv
// Directed bench for upsample_fir_ctrl with hand-computed filter results.
module tb_upsample_fir_ctrl;

   logic        Clock_50 = 1'b0;
   logic        Resetn;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] in_samples;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [31:0] out_raw;

   int n_vec  = 0;
   int n_miss = 0;

   always #10 Clock_50 = ~Clock_50;

   upsample_fir_ctrl #(.SAMPLE_W(8), .ACC_W(32)) dut (
      .Clock_50   (Clock_50),
      .Resetn     (Resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_samples (in_samples),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_raw    (out_raw)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", tag, $signed(obs), obs,
                  $signed(exp), exp);
      end
   endtask

   // Presents a group for one accept edge; returns at the negedge after that edge.
   task automatic send(input logic [47:0] s);
      @(negedge Clock_50);
      in_samples = s;
      in_valid   = 1'b1;
      @(negedge Clock_50);
      in_valid   = 1'b0;
      in_samples = {$urandom, $urandom_range(65535, 0)};
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         @(negedge Clock_50);
         cyc++;
      end
   endtask

   task automatic run_group(input string tag, input logic [47:0] s,
                            input int exp_raw, input int exp_data);
      int cyc;
      send(s);
      wait_done(cyc);
      chk({tag, "_latency"}, cyc, 7);
      chk({tag, "_raw"}, out_raw, exp_raw);
      chk({tag, "_data"}, {24'd0, out_data}, exp_data);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 0);
      out_ready = 1'b1;
      @(negedge Clock_50);
      out_ready = 1'b0;
      chk({tag, "_vld_drop"}, {31'd0, out_valid}, 0);
      chk({tag, "_rdy_back"}, {31'd0, in_ready}, 1);
   endtask

   localparam logic [47:0] ALL0   = 48'd0;
   localparam logic [47:0] ALL100 = {6{8'd100}};
   localparam logic [47:0] ALL255 = {6{8'd255}};
   localparam logic [47:0] NEG    = {8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0};
   localparam logic [47:0] OVR    = {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0};
   localparam logic [47:0] RAMP   = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};

   initial begin
      int cyc, t1, t2, n_res;
      logic b_pending;
      Resetn     = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_samples = '0;
      #35;
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_out_raw", out_raw, 0);
      chk("rst_out_data", {24'd0, out_data}, 0);
      Resetn = 1'b1;

      run_group("zero", ALL0, 128, 0);
      run_group("all100", ALL100, 25728, 100);
      run_group("all255", ALL255, 65408, 255);
      run_group("negclip", NEG, -26392, 0);
      run_group("ovrclip", OVR, 81218, 255);
      run_group("ramp", RAMP, 9088, 35);

      // Backpressure: hold out_ready low for 5 cycles in DONE.
      send(RAMP);
      wait_done(cyc);
      chk("bp_latency", cyc, 7);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock_50);
         chk("bp_valid", {31'd0, out_valid}, 1);
         chk("bp_in_ready", {31'd0, in_ready}, 0);
         chk("bp_raw", out_raw, 9088);
         chk("bp_data", {24'd0, out_data}, 35);
      end
      out_ready = 1'b1;
      @(negedge Clock_50);
      out_ready = 1'b0;
      chk("bp_release", {31'd0, in_ready}, 1);

      // Back-to-back with out_ready tied high.
      @(negedge Clock_50);
      out_ready  = 1'b1;
      in_samples = ALL100;
      in_valid   = 1'b1;
      t1 = 0; t2 = 0; n_res = 0; b_pending = 1'b0;
      for (int c = 1; c <= 40 && n_res < 2; c++) begin
         @(negedge Clock_50);
         if (c == 1) in_samples = RAMP;
         if (b_pending) begin
            in_valid  = 1'b0;
            b_pending = 1'b0;
         end
         if (out_valid) begin
            if (n_res == 0) begin
               t1 = c;
               chk("b2b_raw_a", out_raw, 25728);
            end else begin
               t2 = c;
               chk("b2b_raw_b", out_raw, 9088);
            end
            n_res++;
         end else if (in_ready && n_res == 1 && in_valid) begin
            b_pending = 1'b1;
         end
      end
      in_valid  = 1'b0;
      chk("b2b_count", n_res, 2);
      chk("b2b_spacing", t2 - t1, 9);
      @(negedge Clock_50);
      out_ready = 1'b0;

      // Reset pulsed while in ACC3, then a clean group.
      send(ALL255);
      repeat (4) @(negedge Clock_50);
      Resetn = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_raw", out_raw, 0);
      chk("mid_rst_idle", {31'd0, in_ready}, 1);
      #4;
      Resetn = 1'b1;
      run_group("post_rst", ALL100, 25728, 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/upsample_fir_ctrl.md
# upsample_fir_ctrl

Sequencing controller that runs one 6-tap chroma upsampling interpolation on a single shared accumulate/subtract MAC. A tap group arrives over a valid/ready handshake. The block issues a bias load, then six weighted accumulate or subtract steps, then presents the rounded, clipped 8-bit result downstream over a second valid/ready handshake. It sits between the chroma fetch logic and the colour-space-conversion stage in the milestone 1 datapath.

## Interface
- Parameters
  - SAMPLE_W, 8: width of each input sample and of out_data.
  - ACC_W, 32: accumulator width.
- Ports
  - Clock_50  in  1  system clock, all logic rising-edge.
  - Resetn  in  1  asynchronous, active-low reset.
  - in_valid  in  1  tap group on in_samples is valid.
  - in_ready  out  1  block can accept a tap group. High only in IDLE.
  - in_samples  in  6*SAMPLE_W  packed taps, LSB first: U[j-5], U[j-3], U[j-1], U[j+1], U[j+3], U[j+5]. Unsigned.
  - out_valid  out  1  out_data and out_raw are valid.
  - out_ready  in  1  downstream accepts the result.
  - out_data  out  SAMPLE_W  clip(out_raw >>> 8) to the range 0..255.
  - out_raw  out  ACC_W  signed accumulator value. Debug/verification use.

## Operation
- Filter: raw = 128 + 21·U[j-5] − 52·U[j-3] + 159·U[j-1] + 159·U[j+1] − 52·U[j+3] + 21·U[j+5]. The coefficients sum to 256.
- FSM states: IDLE → LOAD → ACC0…ACC5 → DONE → IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register all six samples and go to LOAD.
  - LOAD: MAC enable_ffn=0, use_default=1, reset_parameter=128.
  - ACCk: MAC enable_ffn=0, use_default=0, value = |coef[k]|·sample[k], zero-extended to ACC_W.
    - subtract=1 for k=1 and k=4; subtract=0 otherwise.
    - ACC5 goes to DONE.
  - DONE: out_valid=1. Stay in DONE until out_ready=1, then go to IDLE.
- MAC enable_ffn=1 (hold) in IDLE and DONE.
- Arithmetic:
  - The accumulator is signed ACC_W wide; the range −26392..91928 never overflows.
  - out_data = 0 if raw<0; 255 if (raw>>>8)>255; else raw[15:8].
- in_samples is don't-care outside the accepting cycle. The registered copy is used throughout.
- No overlap: the next group is accepted only after DONE completes.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_raw=0, accumulator=0, sample registers=0.
- Latency: for an accept at edge E0, out_valid rises after edge E7 (LOAD at E1, ACC0–ACC5 at E2–E7).
- Throughput: one result per 9 cycles with out_ready held high (accept, LOAD, 6×ACC, DONE).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_raw and the accumulator hold stable; in_ready stays 0.
- out_valid and in_ready are never both 1. out_valid is registered: it rises with the state=DONE transition.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Reset asserted mid-operation (any state): return to the reset values immediately and asynchronously. The partial result is discarded and nothing is emitted. The first accept is possible at the first edge after release.

## Structure
- Shared package upsample_pkg holds:
  - the state enum;
  - the coefficient magnitudes 21/52/159;
  - the per-tap subtract mask 6'b010010;
  - the rounding bias 128;
  - the shift amount 8.
- One sub-module: milestone1_mac (the team's accumulator). Its interface:
  - active-low enable_ffn; use_default loads reset_parameter; subtract selects − over +; result is registered and resets to 0.
- The controller owns the FSM, tap counter, sample register, coefficient multiply mux (constant multiplies, one per tap select) and output clip logic.

## Test plan
- Reset, then all taps=0 → out_raw=128, out_data=0, out_valid high 7 edges after accept.
- All taps=100 → out_raw=25728, out_data=100. All taps=255 → out_raw=65408, out_data=255.
- U[j-3]=U[j+3]=255, others 0 → out_raw=−26392, out_data=0 (negative clip).
- U[j-1]=U[j+1]=255, others 0 → out_raw=81218, out_data=255 (overshoot clip).
- Backpressure and back-to-back:
  - out_ready low for 5 cycles in DONE → outputs stable, in_ready=0 throughout.
  - With out_ready tied high, two back-to-back groups produce results 9 cycles apart.
- Resetn pulsed low during ACC3 → out_valid=0, out_raw=0, state=IDLE. The next group (all taps 100) yields 100.
